// File: rtl/serial_shift_controller.sv
// Parallel-to-serial shifter with a valid/ready load port and an MSB-first serial output.
// A word is loaded in IDLE, shifted out over width unstalled SHIFT cycles, then done pulses for one cycle.
module serial_shift_controller #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    input  logic             stall,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] q
);

    localparam int CW = (width > 2) ? $clog2(width) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [width-1:0] r_q;
    logic [width-1:0] w_q_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_q_next     = in_data;
                    w_cnt_next   = '0;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A stalled edge freezes everything, so sout holds the current bit.
                if (!stall) begin
                    w_q_next   = {r_q[width-2:0], 1'b0};
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_SHIFT);
    assign done     = (r_state == S_DONE);
    assign sout     = (r_state == S_SHIFT) && r_q[width-1];
    assign q        = r_q;

endmodule

// File: doc/serial_shift_controller.md
SERIAL_SHIFT_CONTROLLER -- requirements
Module: serial_shift_controller

Interface
REQ-001 Parameter: width, default 8, data word width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; while low, all state is held at its reset value.
REQ-004 in_valid  input  1  a parallel word is offered on in_data.
REQ-005 in_ready  output  1  controller can accept a word this cycle.
REQ-006 in_data  input  width  parallel word to serialize; MSB is sent first.
REQ-007 stall  input  1  freezes shifting while high.
REQ-008 sout  output  1  serial data out.
REQ-009 busy  output  1  high while a word is being shifted out.
REQ-010 done  output  1  one-cycle pulse when a word completes.
REQ-011 q  output  width  current shift register contents.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; encoding is free.
REQ-013 IDLE: in_ready=1, busy=0, done=0, sout=0.
REQ-014 Handshake: a word transfers on a rising edge where in_valid=1 and in_ready=1; at that edge q<=in_data, bit counter<=0, state->SHIFT.
REQ-015 IDLE with in_valid=0: stay in IDLE; q holds its value.
REQ-016 SHIFT outputs: in_ready=0, busy=1, done=0, sout=q[width-1] (combinational from registers).
REQ-017 SHIFT with stall=0 at an edge: q<={q[width-2:0],1'b0}; counter increments.
REQ-018 SHIFT with stall=1 at an edge: q, counter, state and sout are unchanged.
REQ-019 SHIFT exit: an edge with stall=0 and counter=width-1 moves state->DONE; exactly width unstalled SHIFT cycles occur per word.
REQ-020 DONE: lasts exactly one cycle; done=1, busy=0, in_ready=0, sout=0; then state->IDLE; stall is ignored.
REQ-021 Timing, handshake at edge k, no stalls: in_data[width-1-i] is driven on sout in cycle k+1+i for i=0..width-1; done=1 in cycle k+1+width; in_ready=1 again from cycle k+2+width.
REQ-022 in_valid and in_data are ignored outside IDLE; changing in_data mid-word does not affect sout.
REQ-023 stall is ignored in IDLE and DONE.
REQ-024 Back-to-back words: with in_valid held high, the next word is accepted on the first IDLE edge; minimum cadence is width+2 cycles per word.
REQ-025 No combinational path from in_valid, in_data or stall to any output.

Reset
REQ-026 When reset goes low: state=IDLE, q=0, counter=0, sout=0, busy=0, done=0, in_ready=1; takes effect immediately, without waiting for a clock edge.
REQ-027 Reset asserted mid-word aborts the word; no done pulse is produced for it.
REQ-028 The first handshake is possible on the first rising edge after reset deasserts.

Verification (width=8)
REQ-029 Hold reset low 15 ns, clock period 10 ns -> q=0, sout=0, busy=0, done=0, in_ready=1 throughout reset; also assert reset asynchronously between edges and check outputs change immediately.
REQ-030 Send 8'b1001_0110 with handshake at edge k -> sout=1,0,0,1,0,1,1,0 in cycles k+1..k+8; done=1 only in cycle k+9; in_ready=1 from cycle k+10.
REQ-031 Send 8'hA5 with stall=1 for 3 cycles starting cycle k+3 -> bit 2 (value 1) held on sout for 4 cycles; full sequence 1,0,1,0,0,1,0,1 is otherwise intact; done in cycle k+12.
REQ-032 in_valid held high with 8'hFF then 8'h00 -> second word accepted at edge k+10; sout all 1s for 8 cycles, two cycles at 0 (DONE, IDLE), then all 0s for 8 cycles; two done pulses 10 cycles apart.
REQ-033 Reset pulsed low during bit 4 of 8'hC3 -> outputs return to reset values at once; no done pulse; a following 8'h81 transfers correctly.
REQ-034 Toggle in_valid and change in_data during SHIFT -> in_ready stays 0; sout sequence matches the originally accepted word.
